// File: rtl/mpu_matrix_loader.sv
// -----------------------------------------------------------------------------
// mpu_matrix_loader
//
// Write-side front end for the MPU operation units. A square signed int8
// matrix arrives as a row-major element stream over a valid/ready handshake.
// The loader places each element in a packed DIM x DIM matrix bus. It
// zero-fills every position outside the requested size and pulses done for
// one cycle when the last element is stored. The matrix and size word then
// hold until the next accepted start.
//
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   start     in   begin a load (sampled only in IDLE)
//   size      in   signed requested dimension, sampled with start
//   in_valid  in   in_data carries an element
//   in_data   in   signed element, row-major order
//   in_ready  out  element accepted this cycle when in_valid is also high
//   matrix    out  packed matrix, element (r,c) at [r*DIM*ELEM_W + c*ELEM_W +: ELEM_W]
//   size_out  out  dimension of the held matrix
//   busy      out  high while loading
//   done      out  one-cycle pulse after the last element is stored
//   error     out  one-cycle pulse after a start with an out-of-range size
// -----------------------------------------------------------------------------
module mpu_matrix_loader #(
    parameter int DIM    = 5,
    parameter int ELEM_W = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic [7:0]                  size,
    input  logic                        in_valid,
    input  logic [ELEM_W-1:0]           in_data,
    output logic                        in_ready,
    output logic [0:DIM*DIM*ELEM_W-1]   matrix,
    output logic [7:0]                  size_out,
    output logic                        busy,
    output logic                        done,
    output logic                        error
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] ROW_STRIDE = 8'(DIM * ELEM_W);
    localparam logic [7:0] COL_STRIDE = 8'(ELEM_W);
    localparam logic [7:0] MAX_SIZE   = 8'(DIM);

    state_t                      r_state;
    logic [0:DIM*DIM*ELEM_W-1]   r_matrix;
    logic [7:0]                  r_size_out;
    logic [2:0]                  r_row;
    logic [2:0]                  r_col;
    logic                        r_in_ready;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_error;

    logic                        w_size_ok;
    logic                        w_xfer;
    logic [2:0]                  w_dim_m1;
    logic                        w_last_col;
    logic                        w_last_row;
    logic [7:0]                  w_idx;

    // size is a signed byte, so 0 and all negative values are rejected along
    // with anything larger than the maximum dimension.
    assign w_size_ok  = ($signed(size) > 8'sd0) && ($signed(size) <= $signed(MAX_SIZE));
    assign w_xfer     = in_valid && r_in_ready;
    // size_out is 1..DIM while loading, so its low three bits are the whole value.
    assign w_dim_m1   = r_size_out[2:0] - 3'd1;
    assign w_last_col = (r_col == w_dim_m1);
    assign w_last_row = (r_row == w_dim_m1);
    assign w_idx      = ({5'd0, r_row} * ROW_STRIDE) + ({5'd0, r_col} * COL_STRIDE);

    // Loader state machine: handshake, element placement and status pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_matrix   <= '0;
            r_size_out <= 8'd0;
            r_row      <= 3'd0;
            r_col      <= 3'd0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            // Pulses last one cycle unless a branch below re-asserts them.
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    if (start) begin
                        if (w_size_ok) begin
                            r_size_out <= size;
                            r_matrix   <= '0;
                            r_row      <= 3'd0;
                            r_col      <= 3'd0;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b1;
                            r_state    <= ST_LOAD;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (w_xfer) begin
                        r_matrix[w_idx +: ELEM_W] <= in_data;
                        if (w_last_col) begin
                            r_col <= 3'd0;
                            if (w_last_row) begin
                                // Final element: ready drops on this same edge.
                                r_row      <= 3'd0;
                                r_in_ready <= 1'b0;
                                r_busy     <= 1'b0;
                                r_done     <= 1'b1;
                                r_state    <= ST_DONE;
                            end else begin
                                r_row <= r_row + 3'd1;
                            end
                        end else begin
                            r_col <= r_col + 3'd1;
                        end
                    end else begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready = r_in_ready;
    assign matrix   = r_matrix;
    assign size_out = r_size_out;
    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// -----------------------------------------------------------------------------
// Self-checking bench for mpu_matrix_loader. The stimulus process drives loads
// and rejected starts. It also keeps an element-array model of the held
// matrix and queues the expected result of each done or error pulse. A
// separate monitor pops the queue whenever the DUT pulses done or error.
// -----------------------------------------------------------------------------
module tb_mpu_matrix_loader;

    logic         clock;
    logic         reset;
    logic         start;
    logic [7:0]   size;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_ready;
    logic [0:199] matrix;
    logic [7:0]   size_out;
    logic         busy;
    logic         done;
    logic         error;

    mpu_matrix_loader #(.DIM(5), .ELEM_W(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .size     (size),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .matrix   (matrix),
        .size_out (size_out),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        bit           is_err;
        logic [7:0]   sz;
        logic [0:199] mat;
    } exp_t;

    exp_t       exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] mdl_e [0:4][0:4];
    logic [7:0] mdl_size;
    logic [7:0] vals [0:24];

    function automatic void chk(string nm, logic [199:0] act, logic [199:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endfunction

    function automatic logic [0:199] pack_model();
        logic [0:199] m;
        m = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                m[r*40 + c*8 +: 8] = mdl_e[r][c];
        return m;
    endfunction

    function automatic void clear_model(logic [7:0] sz);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                mdl_e[r][c] = 8'd0;
        mdl_size = sz;
    endfunction

    // Monitor: every done/error pulse must match the head of the queue.
    always @(negedge clock) begin
        exp_t e;
        if (done === 1'b1 || error === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {done, error}, 2'b00);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_kind", {done, error}, e.is_err ? 2'b01 : 2'b10);
                chk("held_matrix", matrix, e.mat);
                chk("held_size", size_out, e.sz);
            end
        end
    end

    // One complete load of sz*sz elements from vals[]. gap: 0 none, 1 toggle,
    // 2 random. poke adds in_valid in IDLE, start in LOAD and start in DONE.
    task automatic do_load(int sz, int gap, bit poke);
        int k;
        int cyc;
        bit v;
        bit acc;
        exp_t e;
        if (poke) begin
            in_valid = 1'b1;
            in_data  = 8'hAA;
            repeat (2) @(posedge clock);
            #1;
            @(negedge clock);
            chk("idle_ready_low", in_ready, 1'b0);
        end
        start = 1'b1;
        size  = sz[7:0];
        @(posedge clock);
        #1;
        start    = 1'b0;
        size     = 8'($urandom);
        in_valid = 1'b0;
        clear_model(sz[7:0]);
        k   = 0;
        cyc = 0;
        while (k < sz*sz && cyc < 400) begin
            if (gap == 0)      v = 1'b1;
            else if (gap == 1) v = (cyc % 2 == 0);
            else               v = ($urandom_range(0, 2) != 0);
            in_valid = v;
            in_data  = v ? vals[k] : 8'($urandom);
            if (poke && cyc == 2) begin
                start = 1'b1;
                size  = 8'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            if (cyc == 0) begin
                chk("first_load_ready", in_ready, 1'b1);
                chk("first_load_busy", busy, 1'b1);
            end
            acc = in_valid && in_ready;
            if (acc) begin
                mdl_e[k / sz][k % sz] = vals[k];
                k++;
                if (k == sz*sz) begin
                    e.is_err = 1'b0;
                    e.sz     = mdl_size;
                    e.mat    = pack_model();
                    exp_q.push_back(e);
                end
            end
            @(posedge clock);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (k < sz*sz) chk("load_timeout", 32'(k), 32'(sz*sz));
        if (poke) begin
            start    = 1'b1;
            size     = 8'd2;
            in_valid = 1'b1;
        end
        @(negedge clock);
        chk("done_pulse", done, 1'b1);
        chk("done_busy", busy, 1'b0);
        chk("done_ready", in_ready, 1'b0);
        @(posedge clock);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        chk("done_one_cycle", done, 1'b0);
        chk("back_idle", {busy, in_ready}, 2'b00);
    endtask

    // Start with an out-of-range size; expect one error pulse, nothing changed.
    task automatic do_bad(int sz);
        exp_t e;
        e.is_err = 1'b1;
        e.sz     = mdl_size;
        e.mat    = pack_model();
        exp_q.push_back(e);
        start = 1'b1;
        size  = sz[7:0];
        @(posedge clock);
        #1;
        start = 1'b0;
        @(negedge clock);
        chk("bad_start_idle", {busy, in_ready}, 2'b00);
        @(negedge clock);
        chk("bad_error_one_cycle", error, 1'b0);
    endtask

    initial begin
        int bad;
        reset    = 1'b1;
        start    = 1'b0;
        size     = 8'd0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        clear_model(8'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("reset_matrix", matrix, 200'd0);
        chk("reset_size", size_out, 8'd0);
        chk("reset_flags", {busy, in_ready, done, error}, 4'b0000);

        // Reset in the middle of a 2x2 load.
        start = 1'b1;
        size  = 8'd2;
        @(posedge clock);
        #1;
        start    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'(i + 9);
            @(posedge clock);
            #1;
        end
        in_data = 8'd12;
        reset   = 1'b1;
        @(posedge clock);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        chk("midload_reset_matrix", matrix, 200'd0);
        chk("midload_reset_size", size_out, 8'd0);
        chk("midload_reset_flags", {busy, in_ready}, 2'b00);
        repeat (3) @(negedge clock);

        // 2x2, continuous valid.
        for (int i = 0; i < 4; i++) vals[i] = 8'(i + 1);
        do_load(2, 0, 1'b0);
        chk("p2_b00", matrix[0 +: 8], 8'd1);
        chk("p2_b01", matrix[8 +: 8], 8'd2);
        chk("p2_b10", matrix[40 +: 8], 8'd3);
        chk("p2_b11", matrix[48 +: 8], 8'd4);

        // 5x5, valid toggling every other cycle.
        for (int i = 0; i < 25; i++) vals[i] = 8'(i + 1);
        do_load(5, 1, 1'b0);
        chk("p3_b44", matrix[192 +: 8], 8'd25);
        chk("p3_b23", matrix[104 +: 8], 8'd14);

        // 3x3 of -1 then a 1x1 of 7: no residue allowed.
        for (int i = 0; i < 25; i++) vals[i] = 8'hFF;
        do_load(3, 0, 1'b0);
        vals[0] = 8'd7;
        do_load(1, 2, 1'b0);
        chk("p4_matrix", matrix, {8'd7, 192'd0});
        chk("p4_size", size_out, 8'd1);

        // Rejected sizes keep the 1x1 result.
        do_bad(0);
        do_bad(6);
        do_bad(-3);
        chk("p5_matrix_kept", matrix, {8'd7, 192'd0});

        // Stray start/valid in every state must not disturb a 3x3 load.
        for (int i = 0; i < 25; i++) vals[i] = 8'($urandom);
        do_load(3, 2, 1'b1);

        // Randomized mix.
        for (int t = 0; t < 14; t++) begin
            for (int i = 0; i < 25; i++) vals[i] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0:       bad = 0;
                    1:       bad = int'($urandom_range(6, 127));
                    default: bad = -int'($urandom_range(1, 128));
                endcase
                do_bad(bad);
            end
            do_load(int'($urandom_range(1, 5)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        repeat (4) @(negedge clock);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mpu_matrix_loader.md
Name: mpu_matrix_loader

Overview:
Write-side front end for the MPU operation units. It accepts a square int8 matrix as a row-major element stream with a valid/ready handshake. It assembles the elements into the packed 5x5 matrix bus and the size word that the operation units (determinant etc.) consume. It zero-fills all unused positions and signals completion with a one-cycle done pulse, then holds the matrix stable until the next load.

Parameters:
DIM, 5, maximum matrix dimension; fixed at 5 for this revision.
ELEM_W, 8, element width in bits (signed two's complement).

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  begin a load; sampled only in IDLE
size  in  8  signed matrix dimension requested; sampled with start
in_valid  in  1  in_data carries an element
in_data  in  8  signed element, row-major order
in_ready  out  1  loader accepts in_data this cycle
matrix  out  200  packed matrix, declared ascending [0:199]; element (r,c) at [(r*40)+(c*8) +: 8], so (0,0) is the leftmost/most-significant byte
size_out  out  8  dimension of the held matrix
busy  out  1  high while in LOAD
done  out  1  one-cycle pulse when the last element has been stored
error  out  1  one-cycle pulse on a rejected start

Behaviour:
- Reset (synchronous, clock edge with reset=1):
  - state=IDLE; matrix=0; size_out=0; row=col=0.
  - in_ready, busy, done, error all 0.
  - Reset overrides every other input, including mid-LOAD; a partial load is discarded.
- States: IDLE, LOAD, DONE.
- IDLE:
  - in_ready=0; in_valid/in_data are ignored.
  - start=1 with size in 1..5:
    - Latch size into size_out.
    - Clear matrix to 0.
    - row=col=0; next state LOAD.
  - start=1 with size <=0 or size >5 (signed compare):
    - error=1 for the next cycle; state stays IDLE.
    - matrix and size_out are unchanged.
- LOAD:
  - busy=1; in_ready=1 (registered, asserted from the first LOAD cycle).
  - Transfer occurs when in_valid && in_ready. On each transfer:
    - Write in_data to element (row,col).
    - col increments; when col==size_out-1, col returns to 0 and row increments.
  - Writes only touch positions with row<size_out and col<size_out; all others stay 0.
  - Throughput: one element per cycle; in_valid gaps simply stall the load.
  - start is ignored in LOAD.
  - Transfer of element (size_out-1, size_out-1) moves the state to DONE; in_ready drops on that same edge.
  - Total transfers per load = size_out*size_out (1, 4, 9, 16, 25).
- DONE:
  - Lasts exactly one cycle: done=1, busy=0, in_ready=0; then IDLE.
  - Latency: done is asserted the cycle after the final accepted element.
- Output stability:
  - matrix and size_out change only during LOAD, on a valid start, or on reset.
  - They hold their values indefinitely in IDLE, so downstream units may sample them at any time after done.
- Simultaneous events:
  - start during DONE is ignored (not latched).
  - in_valid during IDLE/DONE is not consumed; in_ready=0.
- Arithmetic: no arithmetic on element values; bytes are stored bit-exact. Row/col counters are 3 bits and saturate by construction (never exceed 4).

Test Plan:
1. Reset mid-load: after 3 of 4 elements for size=2, assert reset 1 cycle -> matrix=0, size_out=0, busy=0, in_ready=0; no done.
2. size=2 load of 1,2,3,4 with in_valid held high -> 4 transfers on consecutive cycles; done pulses the cycle after the 4th. Result: matrix[0+:8]=1, [8+:8]=2, [40+:8]=3, [48+:8]=4, all other bytes 0, size_out=2.
3. size=5 load of values 1..25 with in_valid toggling every other cycle -> exactly 25 transfers; element (r,c)=5r+c+1; byte at [160+32 +: 8]=25; done 1 cycle.
4. size=3 load of -1 (8'hFF) everywhere, then a size=1 load of 7 -> after the second done: matrix[0+:8]=7, every other byte 0 (no residue from the 3x3), size_out=1.
5. start with size=0, then 6, then -3 -> error pulses once per start; state stays IDLE; previous matrix and size_out unchanged; in_ready stays 0.
6. start asserted during LOAD and during DONE, plus in_valid=1 in IDLE -> none of these alter the load; no extra element is consumed; the loaded matrix matches the expected data.
